// File: rtl/seq_det_ctrl_if.sv
// Host/stream-side bundle for the programmable sequence detector:
// configuration, run control, serial bits and run status.
interface seq_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
);
    logic               cfg_wr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TO_W-1:0]    cfg_timeout;
    logic               start;
    logic               abort;
    logic               bit_valid;
    logic               sequence_in;
    logic               busy;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               timeout_flag;
    logic [1:0]         state_out;

    modport master (
        output cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
               start, abort, bit_valid, sequence_in,
        input  busy, match_pulse, match_count, done, timeout_flag, state_out
    );

    modport slave (
        input  cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
               start, abort, bit_valid, sequence_in,
        output busy, match_pulse, match_count, done, timeout_flag, state_out
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detector that runs one detection pass and
// ends on a match target, an idle timeout or an abort.
//
// state  | meaning
// IDLE   | waiting for start; config writable
// RUN    | sampling bits, counting matches, timer active
// DONE   | run finished by target or timeout; results held
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic          clock,
    input  logic          reset,
    seq_det_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

    state_t             r_state;
    state_t             w_next;
    logic [MAX_LEN-1:0] r_pattern;
    logic [3:0]         r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic [TO_W-1:0]    r_timeout;
    logic [MAX_LEN-1:0] r_shift;
    logic [3:0]         r_hist;
    logic [TO_W-1:0]    r_timer;
    logic [CNT_W-1:0]   r_count;
    logic               r_pulse;
    logic               r_tflag;

    logic [3:0]         w_len_eff;
    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_shift_next;
    logic [3:0]         w_hist_next;
    logic [TO_W-1:0]    w_timer_inc;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_match;
    logic               w_timeout_hit;
    logic               w_target_hit;
    logic               w_start_ok;

    always_comb begin
        // raw length is stored so a cleared config still means a 1-bit pattern
        if (r_len == 4'd0)
            w_len_eff = 4'd1;
        else if (r_len > LEN_MAX)
            w_len_eff = LEN_MAX;
        else
            w_len_eff = r_len;
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (4'(i) < w_len_eff);
        w_shift_next  = {r_shift[MAX_LEN-2:0], bus.sequence_in};
        w_hist_next   = (r_hist >= LEN_MAX) ? LEN_MAX : r_hist + 4'd1;
        w_timer_inc   = r_timer + TO_W'(1);
        w_count_inc   = (&r_count) ? r_count : r_count + CNT_W'(1);
        w_match       = (r_state == S_RUN) && bus.bit_valid && !bus.abort &&
                        (w_hist_next >= w_len_eff) &&
                        (((w_shift_next ^ r_pattern) & w_mask) == '0);
        w_timeout_hit = (r_state == S_RUN) && !bus.abort && !w_match &&
                        (r_timeout != '0) && (w_timer_inc == r_timeout);
        w_target_hit  = w_match && (r_target != '0) && (w_count_inc == r_target);
        w_start_ok    = bus.start && !bus.abort && (r_state != S_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.state_out = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok)
                    w_next = S_RUN;
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (bus.abort)
                    w_next = S_IDLE;
                else if (w_target_hit || w_timeout_hit)
                    w_next = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                if (bus.abort)
                    w_next = S_IDLE;
                else if (w_start_ok)
                    w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_target  <= '0;
            r_timeout <= '0;
            r_shift   <= '0;
            r_hist    <= '0;
            r_timer   <= '0;
            r_count   <= '0;
            r_pulse   <= 1'b0;
            r_tflag   <= 1'b0;
        end else begin
            r_pulse <= w_match;
            if (bus.cfg_wr && (r_state != S_RUN)) begin
                r_pattern <= bus.cfg_pattern;
                r_len     <= bus.cfg_len;
                r_overlap <= bus.cfg_overlap;
                r_target  <= bus.cfg_target;
                r_timeout <= bus.cfg_timeout;
            end
            if (bus.abort) begin
                r_tflag <= 1'b0;
            end else if (w_start_ok) begin
                r_shift <= '0;
                r_hist  <= '0;
                r_timer <= '0;
                r_count <= '0;
                r_tflag <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (bus.bit_valid) begin
                    r_shift <= w_shift_next;
                    r_hist  <= (w_match && !r_overlap) ? 4'd0 : w_hist_next;
                end
                if (w_match) begin
                    r_timer <= '0;
                    r_count <= w_count_inc;
                end else begin
                    r_timer <= w_timer_inc;
                end
                r_tflag <= w_timeout_hit;
            end
        end
    end

    assign bus.match_pulse  = r_pulse;
    assign bus.match_count  = r_count;
    assign bus.timeout_flag = r_tflag;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: hand-computed pulse/count/status
// expectations for pattern, overlap, target, timeout, abort and reset cases.
module tb_seq_det_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8), .TO_W(16)) bus ();

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .TO_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                       input logic [7:0] tgt, input logic [15:0] to);
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ov;
        bus.cfg_target  = tgt;
        bus.cfg_timeout = to;
        bus.cfg_wr      = 1'b1;
        tick();
        bus.cfg_wr      = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic send(input logic b, input logic exp_p, input string tag);
        bus.bit_valid   = 1'b1;
        bus.sequence_in = b;
        tick();
        bus.bit_valid   = 1'b0;
        chk(tag, bus.match_pulse, exp_p);
    endtask

    task automatic gap(input string tag);
        bus.bit_valid = 1'b0;
        tick();
        chk(tag, bus.match_pulse, 1'b0);
    endtask

    initial begin
        logic [6:0] bits7;
        logic [6:0] exp7;
        int         n;

        bus.cfg_wr = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
        bus.cfg_target = 0; bus.cfg_timeout = 0; bus.start = 0; bus.abort = 0;
        bus.bit_valid = 0; bus.sequence_in = 0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst state", bus.state_out, 2'b00);
        chk("rst count", bus.match_count, 0);
        chk("rst pulse", bus.match_pulse, 0);
        chk("rst tflag", bus.timeout_flag, 0);
        reset = 1'b0;
        tick();

        // overlap: 1011 in 1,0,1,1,0,1,1 matches after bits 4 and 7
        bits7 = 7'b1011011;
        exp7  = 7'b0001001;
        cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0, 16'd0);
        do_start();
        chk("t1 state", bus.state_out, 2'b01);
        for (int i = 6; i >= 0; i--)
            send(bits7[i], exp7[i], $sformatf("t1 pulse bit%0d", 7 - i));
        chk("t1 count", bus.match_count, 2);
        chk("t1 busy", bus.busy, 1);
        do_abort();
        chk("t1 abort state", bus.state_out, 2'b00);

        // non-overlap: only the first match
        exp7 = 7'b0001000;
        cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0, 16'd0);
        do_start();
        for (int i = 6; i >= 0; i--)
            send(bits7[i], exp7[i], $sformatf("t2 pulse bit%0d", 7 - i));
        chk("t2 count", bus.match_count, 1);
        do_abort();

        // target 2 with pattern 11
        cfg(8'b0000_0011, 4'd2, 1'b1, 8'd2, 16'd0);
        do_start();
        send(1'b1, 1'b0, "t3 pulse bit1");
        send(1'b1, 1'b1, "t3 pulse bit2");
        chk("t3 busy mid", bus.busy, 1);
        send(1'b1, 1'b1, "t3 pulse bit3");
        chk("t3 done", bus.done, 1);
        chk("t3 state", bus.state_out, 2'b10);
        chk("t3 tflag", bus.timeout_flag, 0);
        chk("t3 count", bus.match_count, 2);
        chk("t3 busy end", bus.busy, 0);
        do_start();
        chk("t3 rerun count", bus.match_count, 0);
        chk("t3 rerun state", bus.state_out, 2'b01);
        do_abort();

        // timeout 5, stream of zeros never matches 1111
        cfg(8'b0000_1111, 4'd4, 1'b1, 8'd0, 16'd5);
        bus.bit_valid = 1'b1;
        bus.sequence_in = 1'b0;
        do_start();
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        bus.bit_valid = 1'b0;
        chk("t4 run cycles", n, 5);
        chk("t4 done", bus.done, 1);
        chk("t4 tflag", bus.timeout_flag, 1);
        chk("t4 count", bus.match_count, 0);
        do_abort();
        chk("t4 abort tflag", bus.timeout_flag, 0);

        // a match restarts the timer: 4 idle cycles needed after it
        cfg(8'b0000_0011, 4'd2, 1'b1, 8'd0, 16'd4);
        do_start();
        send(1'b1, 1'b0, "t5 pulse a");
        gap("t5 gap a");
        send(1'b1, 1'b1, "t5 pulse b");
        repeat (3) tick();
        chk("t5 not yet done", bus.done, 0);
        tick();
        chk("t5 done", bus.done, 1);
        chk("t5 tflag", bus.timeout_flag, 1);
        chk("t5 count", bus.match_count, 1);
        do_abort();
        chk("t5 abort tflag", bus.timeout_flag, 0);
        chk("t5 abort count", bus.match_count, 1);
        chk("t5 abort state", bus.state_out, 2'b00);

        // gapped 101 plus a config write attempted during RUN
        cfg(8'b0000_0101, 4'd3, 1'b1, 8'd0, 16'd0);
        do_start();
        send(1'b1, 1'b0, "t6 bit1");
        gap("t6 gap1");
        send(1'b0, 1'b0, "t6 bit2");
        gap("t6 gap2");
        gap("t6 gap3");
        send(1'b1, 1'b1, "t6 bit3");
        chk("t6 count", bus.match_count, 1);
        cfg(8'b0000_0001, 4'd1, 1'b1, 8'd0, 16'd0);
        send(1'b1, 1'b0, "t6 cfg ignored");
        chk("t6 still run", bus.state_out, 2'b01);
        do_abort();

        // cfg_len 0 acts as a 1-bit pattern
        cfg(8'b0000_0001, 4'd0, 1'b1, 8'd0, 16'd0);
        do_start();
        send(1'b1, 1'b1, "t7 bit1");
        send(1'b0, 1'b0, "t7 bit2");
        send(1'b1, 1'b1, "t7 bit3");
        chk("t7 count", bus.match_count, 2);
        do_abort();

        // abort beats start
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("t8 abort+start state", bus.state_out, 2'b00);
        chk("t8 abort+start busy", bus.busy, 0);

        // abort mid-run suppresses a match on the abort edge
        cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0, 16'd0);
        do_start();
        send(1'b1, 1'b0, "t9 b1");
        send(1'b0, 1'b0, "t9 b2");
        send(1'b1, 1'b0, "t9 b3");
        send(1'b1, 1'b1, "t9 b4");
        send(1'b0, 1'b0, "t9 b5");
        send(1'b1, 1'b0, "t9 b6");
        bus.abort = 1'b1;
        send(1'b1, 1'b0, "t9 abort pulse");
        bus.abort = 1'b0;
        chk("t9 state", bus.state_out, 2'b00);
        chk("t9 count", bus.match_count, 1);

        // async reset mid-run
        do_start();
        send(1'b1, 1'b0, "t10 b1");
        send(1'b0, 1'b0, "t10 b2");
        send(1'b1, 1'b0, "t10 b3");
        bus.bit_valid = 1'b1;
        bus.sequence_in = 1'b1;
        reset = 1'b1;
        #2;
        chk("t10 rst busy", bus.busy, 0);
        chk("t10 rst state", bus.state_out, 2'b00);
        chk("t10 rst pulse", bus.match_pulse, 0);
        tick();
        reset = 1'b0;
        tick();
        bus.bit_valid = 1'b0;
        chk("t10 post pulse", bus.match_pulse, 0);
        chk("t10 post count", bus.match_count, 0);
        chk("t10 post state", bus.state_out, 2'b00);

        // cleared config: pattern 0, effective length 1
        do_start();
        send(1'b0, 1'b1, "t11 cleared cfg match");
        do_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
